// File: rtl/inst_pkg.sv
// Shared types and constants for the instruction sequencing blocks.
package inst_pkg;

   typedef enum logic [0:0] {
      PC_IDLE,
      PC_RUN
   } pc_state_t;

   localparam int unsigned LOOP_MODE_NONE = 0;
   localparam int unsigned LOOP_MODE_1    = 1;
   localparam int unsigned LOOP_MODE_2    = 2;
   localparam int unsigned LOOP_MODE_3    = 3;

endpackage

// File: rtl/inst_pc_control.sv
// Program-counter sequencer: steps the PC, applies loop-controller jump/done decisions,
// and muxes the instruction-memory address between the PC and a debug address.
module inst_pc_control
   import inst_pkg::*;
#(
   parameter int unsigned InstMemAddrWidth = 32,
   parameter int unsigned LoopNumStates    = 4,
   parameter int unsigned LoopNumWidth     = $clog2(LoopNumStates)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clr_i,
   input  logic                        start_i,
   input  logic                        stall_i,
   input  logic                        dbg_en_i,
   input  logic [InstMemAddrWidth-1:0] dbg_addr_i,
   input  logic [LoopNumWidth-1:0]     inst_loop_mode_i,
   input  logic [InstMemAddrWidth-1:0] inst_last_addr_i,
   input  logic                        inst_jump_i,
   input  logic [InstMemAddrWidth-1:0] inst_jump_addr_i,
   input  logic                        inst_loop_done_i,
   output logic [InstMemAddrWidth-1:0] inst_pc_o,
   output logic                        inst_en_o,
   output logic [InstMemAddrWidth-1:0] inst_addr_o,
   output logic                        busy_o,
   output logic                        done_o
);

   pc_state_t                   state_q, state_d;
   logic [InstMemAddrWidth-1:0] pc_q, pc_d;
   logic                        done_q, done_d;

   logic no_loops;
   logic advance;
   logic end_cond;

   assign no_loops = (inst_loop_mode_i == LoopNumWidth'(LOOP_MODE_NONE));
   assign advance  = !stall_i && !dbg_en_i;
   // Without loops the program ends at a fixed address; otherwise the loop controller decides.
   assign end_cond = no_loops ? (pc_q == inst_last_addr_i) : inst_loop_done_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PC_IDLE;
         pc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = 1'b0;
      if (clr_i) begin
         state_d = PC_IDLE;
         pc_d    = '0;
      end else begin
         unique case (state_q)
            PC_IDLE: begin
               if (start_i && !dbg_en_i) begin
                  state_d = PC_RUN;
                  pc_d    = '0;
               end
            end
            PC_RUN: begin
               if (advance) begin
                  if (end_cond) begin
                     state_d = PC_IDLE;
                     pc_d    = '0;
                     done_d  = 1'b1;
                  end else if (inst_jump_i && !no_loops) begin
                     pc_d = inst_jump_addr_i;
                  end else begin
                     pc_d = pc_q + InstMemAddrWidth'(1);
                  end
               end
            end
            default: begin
               state_d = PC_IDLE;
               pc_d    = '0;
            end
         endcase
      end
   end

   always_comb begin
      inst_pc_o   = pc_q;
      inst_en_o   = (state_q == PC_RUN);
      busy_o      = (state_q == PC_RUN);
      done_o      = done_q;
      inst_addr_o = dbg_en_i ? dbg_addr_i : pc_q;
   end

endmodule

// File: tb/tb_inst_pc_control.sv
// Randomised and directed bench for inst_pc_control against a behavioural program model.
module tb_inst_pc_control;

   localparam int unsigned W = 8;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         clr_i, start_i, stall_i, dbg_en_i;
   logic [W-1:0] dbg_addr_i, inst_last_addr_i, inst_jump_addr_i;
   logic [1:0]   inst_loop_mode_i;
   logic         inst_jump_i, inst_loop_done_i;
   logic [W-1:0] inst_pc_o, inst_addr_o;
   logic         inst_en_o, busy_o, done_o;

   int checks = 0;
   int errors = 0;

   // Reference model: is a program running, where is it, did one just finish.
   bit running;
   int pc;
   bit finished;
   int n_jumps;

   inst_pc_control #(
      .InstMemAddrWidth(W),
      .LoopNumStates   (4)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .clr_i           (clr_i),
      .start_i         (start_i),
      .stall_i         (stall_i),
      .dbg_en_i        (dbg_en_i),
      .dbg_addr_i      (dbg_addr_i),
      .inst_loop_mode_i(inst_loop_mode_i),
      .inst_last_addr_i(inst_last_addr_i),
      .inst_jump_i     (inst_jump_i),
      .inst_jump_addr_i(inst_jump_addr_i),
      .inst_loop_done_i(inst_loop_done_i),
      .inst_pc_o       (inst_pc_o),
      .inst_en_o       (inst_en_o),
      .inst_addr_o     (inst_addr_o),
      .busy_o          (busy_o),
      .done_o          (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("pc", int'(inst_pc_o), pc);
      check_eq("en", int'(inst_en_o), int'(running));
      check_eq("busy", int'(busy_o), int'(running));
      check_eq("done", int'(done_o), int'(finished));
   endtask

   // Called just after a falling edge: drive one cycle of inputs, predict, check after the edge.
   task automatic step(input bit clr, input bit st, input bit stl, input bit dbg,
                       input int da, input int mode, input int last,
                       input bit jmp, input int ja, input bit ld);
      bit ends;
      clr_i            = clr;
      start_i          = st;
      stall_i          = stl;
      dbg_en_i         = dbg;
      dbg_addr_i       = W'(da);
      inst_loop_mode_i = 2'(mode);
      inst_last_addr_i = W'(last);
      inst_jump_i      = jmp;
      inst_jump_addr_i = W'(ja);
      inst_loop_done_i = ld;
      #1;
      check_eq("addr", int'(inst_addr_o), dbg ? (da % 256) : pc);
      if (clr) begin
         running  = 0;
         pc       = 0;
         finished = 0;
      end else begin
         finished = 0;
         if (!running) begin
            if (st && !dbg) begin
               running = 1;
               pc      = 0;
            end
         end else if (!stl && !dbg) begin
            ends = (mode == 0) ? (pc == last) : ld;
            if (ends) begin
               running  = 0;
               pc       = 0;
               finished = 1;
            end else if (jmp && mode != 0) begin
               pc = ja % 256;
            end else begin
               pc = (pc + 1) % 256;
            end
         end
      end
      @(negedge clk_i);
      check_outputs();
   endtask

   // Plain advance in a given mode with no loop-controller activity.
   task automatic idle_step(input int mode, input int last);
      step(0, 0, 0, 0, 0, mode, last, 0, 0, 0);
   endtask

   initial begin
      rst_ni = 1'b0;
      {clr_i, start_i, stall_i, dbg_en_i, inst_jump_i, inst_loop_done_i} = '0;
      dbg_addr_i = '0; inst_last_addr_i = '0; inst_jump_addr_i = '0; inst_loop_mode_i = '0;
      running = 0; pc = 0; finished = 0;
      @(negedge clk_i);
      check_outputs();
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Mode 0 runs 0..3, then done pulse.
      step(0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) idle_step(0, 3);

      // Mode 1: jump 3->1 twice, then done at 3.
      step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      n_jumps = 0;
      for (int i = 0; i < 12; i++) begin
         bit at3;
         at3 = (pc == 3) && running;
         step(0, 0, 0, 0, 0, 1, 0, at3 && n_jumps < 2, 1, at3 && n_jumps == 2);
         if (at3) n_jumps++;
      end

      // Mode 1: stall at PC 2 with a jump pulse, then resume.
      step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle_step(1, 0);
      idle_step(1, 0);
      step(0, 0, 1, 0, 0, 1, 0, 1, 9, 0);
      step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      idle_step(1, 0);

      // Debug freeze at PC 5, start ignored, then advance resumes.
      idle_step(1, 0);
      idle_step(1, 0);
      step(0, 1, 0, 1, 8'h40, 1, 0, 1, 9, 1);
      step(0, 0, 0, 1, 8'h40, 1, 0, 0, 0, 0);
      idle_step(1, 0);

      // Mode 2: jump and done together at PC 7 -> done wins.
      step(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 2, 0, 1, 20, 1);
      step(0, 1, 0, 0, 0, 2, 0, 0, 0, 0);

      // Clear at PC 4.
      for (int i = 0; i < 4; i++) idle_step(2, 0);
      step(1, 1, 0, 0, 0, 2, 0, 1, 1, 1);
      idle_step(2, 0);

      // Wrap from 0xFF to 0 in a loop mode.
      step(0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 3, 0, 1, 8'hFF, 0);
      idle_step(3, 0);

      // Asynchronous reset mid-run.
      idle_step(3, 0);
      #2 rst_ni = 1'b0;
      #1;
      running = 0; pc = 0; finished = 0;
      check_outputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      check_outputs();

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 3) == 0,
              ($urandom_range(0, 3) == 0) ? 8'hFE : $urandom_range(0, 255),
              $urandom_range(0, 7) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
